// File: rtl/clefia_sbox_arb.sv
// -----------------------------------------------------------------------------
// clefia_sbox_arb
//
// Shares one external S0 and one external S1 S-box between two F-function
// requesters: A (data path) and B (key schedule). A granted 32-bit word T
// (byte0 = [31:24] ... byte3 = [7:0]) is substituted in two passes of two
// bytes each, following the CLEFIA F0 or F1 S-box pattern:
//   F0: even bytes -> S0, odd bytes -> S1
//   F1: even bytes -> S1, odd bytes -> S0
// The result is returned on res_word with a one-cycle done pulse.
//
// Handshake (req/gnt/done): a requester raises req with word/ftype stable and
// holds them until it sees its gnt. gnt is a one-cycle registered pulse in the
// first PASS0 cycle; req/word may change from the cycle after gnt. done is a
// one-cycle pulse two cycles after gnt, with res_word valid in that cycle and
// held until the next done. Requests are only sampled in IDLE; when both
// requesters are pending, the one that was not served last wins.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   a_req/a_word/a_ftype requester A request, word, pattern (0 = F0, 1 = F1)
//   a_gnt/a_done        requester A grant and result-valid pulses
//   b_req/b_word/b_ftype requester B request, word, pattern
//   b_gnt/b_done        requester B grant and result-valid pulses
//   res_word            substituted word
//   busy                high whenever an operation is in flight
//   s0_in/s0_out        external S0 lookup (s0_out combinational on s0_in)
//   s1_in/s1_out        external S1 lookup (s1_out combinational on s1_in)
//
// Parameter:
//   IDLE_ZERO  1: s0_in/s1_in are 8'h00 outside the two passes
//              0: they hold their last value
// -----------------------------------------------------------------------------
module clefia_sbox_arb #(
   parameter bit IDLE_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic [31:0] a_word,
   input  logic        a_ftype,
   output logic        a_gnt,
   output logic        a_done,
   input  logic        b_req,
   input  logic [31:0] b_word,
   input  logic        b_ftype,
   output logic        b_gnt,
   output logic        b_done,
   output logic [31:0] res_word,
   output logic        busy,
   output logic [7:0]  s0_in,
   input  logic [7:0]  s0_out,
   output logic [7:0]  s1_in,
   input  logic [7:0]  s1_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS0 = 2'd1,
      PASS1 = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   logic [15:0] low_bytes;   // bytes 2 and 3 of the granted word
   logic        ftype_q;
   logic        owner_b;     // owner of the operation in flight
   logic        last_b;      // 1 when B was served last (reset: B, so A wins first tie)
   logic [15:0] res_hi;      // result bytes 0 and 1 captured in PASS0

   logic        a_win;
   logic        b_win;
   logic [31:0] sel_word;
   logic        sel_ftype;
   logic [7:0]  res_even;
   logic [7:0]  res_odd;

   // Returns {s0_in, s1_in} for an even/odd byte pair under the given pattern.
   function automatic logic [15:0] route(input logic       ftype,
                                         input logic [7:0] even_byte,
                                         input logic [7:0] odd_byte);
      route = ftype ? {odd_byte, even_byte} : {even_byte, odd_byte};
   endfunction

   always_comb begin
      a_win     = a_req & (~b_req | last_b);
      b_win     = b_req & ~a_win;
      sel_word  = a_win ? a_word  : b_word;
      sel_ftype = a_win ? a_ftype : b_ftype;
   end

   // Sbox results for the pair currently on s0_in/s1_in, back in byte order.
   always_comb begin
      res_even = ftype_q ? s1_out : s0_out;
      res_odd  = ftype_q ? s0_out : s1_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         low_bytes <= '0;
         ftype_q   <= 1'b0;
         owner_b   <= 1'b0;
         last_b    <= 1'b1;
         res_hi    <= '0;
         res_word  <= '0;
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         a_done    <= 1'b0;
         b_done    <= 1'b0;
         busy      <= 1'b0;
         s0_in     <= 8'h00;
         s1_in     <= 8'h00;
      end else begin
         a_gnt  <= 1'b0;
         b_gnt  <= 1'b0;
         a_done <= 1'b0;
         b_done <= 1'b0;
         case (state)
            IDLE: begin
               if (a_win || b_win) begin
                  low_bytes      <= sel_word[15:0];
                  ftype_q        <= sel_ftype;
                  owner_b        <= b_win;
                  last_b         <= b_win;
                  a_gnt          <= a_win;
                  b_gnt          <= b_win;
                  busy           <= 1'b1;
                  // Bytes 0/1 are presented straight away so PASS0 can capture.
                  {s0_in, s1_in} <= route(sel_ftype, sel_word[31:24], sel_word[23:16]);
                  state          <= PASS0;
               end
            end
            PASS0: begin
               res_hi         <= {res_even, res_odd};
               {s0_in, s1_in} <= route(ftype_q, low_bytes[15:8], low_bytes[7:0]);
               state          <= PASS1;
            end
            PASS1: begin
               res_word <= {res_hi, res_even, res_odd};
               a_done   <= ~owner_b;
               b_done   <= owner_b;
               if (IDLE_ZERO) begin
                  s0_in <= 8'h00;
                  s1_in <= 8'h00;
               end
               state    <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
